output_sequencer: RTL and testbench
===================================

# output_sequencer

Controller for the histogram-equalization output pipeline. Once the CDF RAM has been filled, it scans the CDF for the first non-zero entry and publishes that value as CdfMin. It then streams every pixel of the frame through a pixel-RAM lookup and a CDF-RAM lookup. Each looked-up CDF value is presented to the output expression stage with a one-cycle start strobe. The expression stage computes (cdf − CdfMin)·255 and registers its result one cycle later.

## Interface
- PIXELS, 65536: pixels per frame (≥1)
- ADDR_W, 16: pixel RAM address width; 2^ADDR_W ≥ PIXELS
- CDF_W, 20: CDF word width
- clock  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- Start  in  1  one-cycle request to process a frame; ignored unless IDLE
- Ready  in  1  downstream issue enable, sampled in RUN
- PixRd  out  1  pixel RAM read strobe
- PixAddr  out  ADDR_W  pixel RAM address
- PixData  in  8  pixel RAM read data, valid the cycle after PixRd
- CdfRd  out  1  CDF RAM read strobe
- CdfAddr  out  8  CDF RAM address
- CdfData  in  CDF_W  CDF RAM read data, valid the cycle after CdfRd
- CdfMin  out  CDF_W  minimum non-zero CDF value, held stable from end of SCAN until next Start
- ExprStart  out  1  strobe to the expression stage StartIn
- ExprData  out  CDF_W  CDF value for the expression stage DataIn
- Busy  out  1  high from the cycle after an accepted Start through the Done cycle
- Done  out  1  one-cycle pulse aligned with the expression stage's last valid output

## Operation
- Reset: state IDLE. PixRd, PixAddr, CdfRd, CdfAddr, CdfMin, ExprStart, Busy and Done are all 0. ExprData is 0.
- States: IDLE → SCAN → RUN → DRAIN → IDLE.
- IDLE: Start=1 → SCAN. CdfMin is cleared to 0 on acceptance.
- SCAN:
  - Issues CdfRd with CdfAddr = 0,1,2,… one address per cycle.
  - Compares the returned CdfData each cycle. The first non-zero word is latched into CdfMin and the state moves to RUN.
  - The one speculative read issued in that same cycle is discarded.
  - If all 256 words are zero, CdfMin stays 0 and the state enters RUN after word 255 is checked. The CDF address counter never wraps.
- RUN: a three-stage pipeline.
  - Stage A: when Ready=1, assert PixRd with PixAddr = i, then increment i. When Ready=0, issue nothing.
  - Stage B: one cycle after a stage-A issue, assert CdfRd with CdfAddr = PixData. This address is combinational from PixData.
  - Stage C: one cycle after a stage-B read, ExprStart=1 and ExprData = CdfData.
  - After issue PIXELS−1 the state moves to DRAIN.
- DRAIN: completes the two in-flight stages. Done is pulsed one cycle after the final ExprStart, then the state returns to IDLE.
- CDF RAM ownership: SCAN and RUN use it exclusively and never overlap, so there is no arbitration.
- Ready=0 stops only new issues. Up to two in-flight pixels still emerge. Downstream must absorb a 2-cycle skid.
- Start while not IDLE is ignored. CdfMin does not change.
- reset_n low at any point aborts the frame immediately, and all outputs return to their reset values asynchronously.

## Timing
- Start sampled in cycle 0. SCAN issues CdfAddr=j in cycle 1+j. Its data is checked in cycle 2+j.
- First non-zero at index k: CdfMin is valid from cycle 3+k, and RUN begins in cycle r = 3+k.
- All-zero CDF: r = 258.
- With Ready held high:
  - pixel i: PixRd at r+i, CdfRd at r+i+1, ExprStart at r+i+2.
  - expression stage output for pixel i at r+i+3.
  - Done at r+PIXELS+2.
- Each Ready=0 cycle in RUN delays all later events by one cycle.
- Throughput: 1 pixel/cycle.
- ExprStart is registered. ExprData is combinational from CdfData.

## Test plan
- CDF all zero except CDF[0]=5, PIXELS=4, Ready=1, Start at cycle 0 → CdfMin=5 from cycle 3. ExprStart in cycles 5–8. Done in cycle 9. Busy high cycles 1–9.
- CDF[0..9]=0, CDF[10]=100, pixels {10,255,10,0} → CdfMin=100. ExprData sequence = CDF[10], CDF[255], CDF[10], CDF[0]. Downstream DataOut for pixel 0 = 0.
- All-zero CDF → RUN enters at cycle 258 with CdfMin=0. No CDF address wrap. Frame completes normally.
- Ready deasserted for 3 cycles mid-RUN → exactly 2 in-flight ExprStarts continue, then a 3-cycle gap. No pixel is lost or duplicated. Done is delayed by 3 cycles.
- Start pulsed during SCAN and during RUN → ignored. CdfMin and the pixel count are unchanged.
- reset_n low mid-RUN → all outputs 0 at once. A new Start after release begins at CdfAddr=0 and PixAddr=0.

Source files
------------

// File: rtl/output_sequencer.sv
// ---------------------------------------------------------------------------
// output_sequencer
//
// Sequencer for the histogram-equalization output pipeline. After a frame
// Start it scans the CDF RAM for the first non-zero word and publishes it as
// CdfMin. It then streams every pixel through a pixel-RAM lookup followed by
// a CDF-RAM lookup, and hands each CDF value to the expression stage with a
// one-cycle strobe.
//
// Ports
//   clock      : single clock, rising edge
//   reset_n    : asynchronous active-low reset
//   Start      : one-cycle frame request, honoured only in IDLE
//   Ready      : downstream issue enable, sampled in RUN
//   PixRd      : pixel RAM read strobe
//   PixAddr    : pixel RAM address
//   PixData    : pixel RAM read data (valid the cycle after PixRd)
//   CdfRd      : CDF RAM read strobe
//   CdfAddr    : CDF RAM address
//   CdfData    : CDF RAM read data (valid the cycle after CdfRd)
//   CdfMin     : first non-zero CDF word, stable from end of SCAN to next Start
//   ExprStart  : strobe to the expression stage
//   ExprData   : CDF value for the expression stage
//   Busy       : high from the cycle after an accepted Start through Done
//   Done       : one-cycle pulse aligned with the last expression result
// ---------------------------------------------------------------------------
module output_sequencer #(
  parameter int PIXELS = 65536,
  parameter int ADDR_W = 16,
  parameter int CDF_W  = 20
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              Start,
  input  logic              Ready,
  output logic              PixRd,
  output logic [ADDR_W-1:0] PixAddr,
  input  logic [7:0]        PixData,
  output logic              CdfRd,
  output logic [7:0]        CdfAddr,
  input  logic [CDF_W-1:0]  CdfData,
  output logic [CDF_W-1:0]  CdfMin,
  output logic              ExprStart,
  output logic [CDF_W-1:0]  ExprData,
  output logic              Busy,
  output logic              Done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIXELS - 1);

  state_t            state_q,      state_d;
  // Bit 8 set means all 256 CDF addresses have been issued; the counter
  // stops there instead of wrapping back to address 0.
  logic [8:0]        scan_addr_q,  scan_addr_d;
  // A SCAN read was issued last cycle, so CdfData is worth checking now.
  logic              scan_chk_q,   scan_chk_d;
  logic [ADDR_W-1:0] pix_cnt_q,    pix_cnt_d;
  // Stage B valid: a pixel read was issued last cycle.
  logic              pix_vld_q,    pix_vld_d;
  // Stage C valid: a CDF lookup was issued last cycle.
  logic              expr_start_q, expr_start_d;
  logic              done_q,       done_d;
  logic [CDF_W-1:0]  cdf_min_q,    cdf_min_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      scan_addr_q  <= '0;
      scan_chk_q   <= 1'b0;
      pix_cnt_q    <= '0;
      pix_vld_q    <= 1'b0;
      expr_start_q <= 1'b0;
      done_q       <= 1'b0;
      cdf_min_q    <= '0;
    end else begin
      state_q      <= state_d;
      scan_addr_q  <= scan_addr_d;
      scan_chk_q   <= scan_chk_d;
      pix_cnt_q    <= pix_cnt_d;
      pix_vld_q    <= pix_vld_d;
      expr_start_q <= expr_start_d;
      done_q       <= done_d;
      cdf_min_q    <= cdf_min_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    scan_addr_d  = scan_addr_q;
    scan_chk_d   = 1'b0;
    pix_cnt_d    = pix_cnt_q;
    pix_vld_d    = 1'b0;
    expr_start_d = 1'b0;
    done_d       = 1'b0;
    cdf_min_d    = cdf_min_q;
    PixRd        = 1'b0;
    PixAddr      = '0;
    CdfRd        = 1'b0;
    CdfAddr      = '0;

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d     = S_SCAN;
          scan_addr_d = '0;
          pix_cnt_d   = '0;
          cdf_min_d   = '0;
        end
      end

      S_SCAN: begin
        CdfRd      = ~scan_addr_q[8];
        CdfAddr    = scan_addr_q[7:0];
        scan_chk_d = ~scan_addr_q[8];
        if (!scan_addr_q[8]) begin
          scan_addr_d = scan_addr_q + 9'd1;
        end
        if (scan_chk_q) begin
          if (CdfData != '0) begin
            // The read issued in this same cycle is speculative and is
            // simply never looked at.
            cdf_min_d = CdfData;
            state_d   = S_RUN;
          end else if (scan_addr_q[8]) begin
            // Word 255 was just checked and was zero: CdfMin stays 0.
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        PixRd        = Ready;
        PixAddr      = pix_cnt_q;
        pix_vld_d    = Ready;
        CdfRd        = pix_vld_q;
        CdfAddr      = pix_vld_q ? PixData : 8'd0;
        expr_start_d = pix_vld_q;
        if (Ready) begin
          pix_cnt_d = pix_cnt_q + ADDR_W'(1);
          if (pix_cnt_q == LAST_PIX) begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        CdfRd        = pix_vld_q;
        CdfAddr      = pix_vld_q ? PixData : 8'd0;
        expr_start_d = pix_vld_q;
        // Final ExprStart is the one with nothing behind it in stage B;
        // Done follows it by one cycle, matching the expression register.
        done_d = expr_start_q & ~pix_vld_q;
        if (done_q) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign CdfMin    = cdf_min_q;
  assign ExprStart = expr_start_q;
  // Gated so the expression input reads 0 whenever no value is presented.
  assign ExprData  = expr_start_q ? CdfData : '0;
  assign Busy      = (state_q != S_IDLE);
  assign Done      = done_q;

endmodule

// File: tb/tb_output_sequencer.sv
// Directed bench for output_sequencer with small frame (4 pixels).
// Cycle n of a frame is the cycle in which Start was driven when n == 0.
module tb_output_sequencer;

  localparam int PIXELS = 4;
  localparam int ADDR_W = 4;
  localparam int CDF_W  = 20;
  localparam int MAXC   = 400;

  logic              clock   = 1'b0;
  logic              reset_n = 1'b0;
  logic              Start   = 1'b0;
  logic              Ready   = 1'b0;
  logic              PixRd;
  logic [ADDR_W-1:0] PixAddr;
  logic [7:0]        PixData;
  logic              CdfRd;
  logic [7:0]        CdfAddr;
  logic [CDF_W-1:0]  CdfData;
  logic [CDF_W-1:0]  CdfMin;
  logic              ExprStart;
  logic [CDF_W-1:0]  ExprData;
  logic              Busy;
  logic              Done;

  int compared   = 0;
  int mismatched = 0;

  output_sequencer #(.PIXELS(PIXELS), .ADDR_W(ADDR_W), .CDF_W(CDF_W)) dut (
    .clock(clock), .reset_n(reset_n), .Start(Start), .Ready(Ready),
    .PixRd(PixRd), .PixAddr(PixAddr), .PixData(PixData),
    .CdfRd(CdfRd), .CdfAddr(CdfAddr), .CdfData(CdfData),
    .CdfMin(CdfMin), .ExprStart(ExprStart), .ExprData(ExprData),
    .Busy(Busy), .Done(Done)
  );

  always #5 clock = ~clock;

  // RAM models with registered reads.
  logic [7:0]       pix_mem [0:15];
  logic [CDF_W-1:0] cdf_mem [0:255];
  logic [7:0]       pix_q = '0;
  logic [CDF_W-1:0] cdf_q = '0;
  assign PixData = pix_q;
  assign CdfData = cdf_q;
  always @(posedge clock) begin
    if (PixRd) pix_q <= pix_mem[PixAddr];
    if (CdfRd) cdf_q <= cdf_mem[CdfAddr];
  end

  // Per-frame event record.
  int pix_cyc[$];
  int pix_adr[$];
  int ex_cyc[$];
  int ex_dat[$];
  int done_cyc, done_cnt, busy_first, busy_last, busy_cnt;
  int scan_rd_cnt, scan_max, scan_first_cyc, scan_first_adr;
  logic [CDF_W-1:0] cm_hist [0:MAXC-1];
  bit to;

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic run_frame(input int lo_from, input int lo_len, input int st_a,
                           input int st_b, input int abort_at, output bit timed_out);
    pix_cyc.delete(); pix_adr.delete(); ex_cyc.delete(); ex_dat.delete();
    done_cyc = -1; done_cnt = 0; busy_first = -1; busy_last = -1; busy_cnt = 0;
    scan_rd_cnt = 0; scan_max = -1; scan_first_cyc = -1; scan_first_adr = -1;
    for (int n = 0; n < MAXC; n++) cm_hist[n] = '1;
    timed_out = 1'b1;
    for (int n = 0; n < MAXC; n++) begin
      @(posedge clock); #1;
      Start = (n == 0) || (n == st_a) || (n == st_b);
      Ready = !(n >= lo_from && n < lo_from + lo_len);
      #1;
      cm_hist[n] = CdfMin;
      if (PixRd) begin pix_cyc.push_back(n); pix_adr.push_back(int'(PixAddr)); end
      if (ExprStart) begin ex_cyc.push_back(n); ex_dat.push_back(int'(ExprData)); end
      if (Done) begin done_cnt++; if (done_cyc < 0) done_cyc = n; end
      if (Busy) begin busy_cnt++; busy_last = n; if (busy_first < 0) busy_first = n; end
      if (CdfRd && pix_cyc.size() == 0) begin
        scan_rd_cnt++;
        if (scan_first_cyc < 0) begin scan_first_cyc = n; scan_first_adr = int'(CdfAddr); end
        if (int'(CdfAddr) > scan_max) scan_max = int'(CdfAddr);
      end
      if (n == abort_at) begin
        reset_n = 1'b0;
        #1;
        Start = 1'b0;
        timed_out = 1'b0;
        return;
      end
      if (done_cyc >= 0 && n == done_cyc + 2) begin
        timed_out = 1'b0;
        break;
      end
    end
    Start = 1'b0;
    Ready = 1'b1;
    $display("frame: pixels=%0d expr=%0d done@%0d cdfmin=%0d", pix_cyc.size(), ex_cyc.size(), done_cyc, CdfMin);
  endtask

  task automatic load_cdf10();
    for (int i = 0; i < 256; i++) cdf_mem[i] = (i < 10) ? '0 : CDF_W'(100 + i - 10);
    pix_mem[0] = 8'd10; pix_mem[1] = 8'd255; pix_mem[2] = 8'd10; pix_mem[3] = 8'd0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    compared++; if ({PixRd, CdfRd, ExprStart, Busy, Done} !== 5'b0) begin mismatched++; $display("FAIL reset_strobes got %b expected 00000", {PixRd, CdfRd, ExprStart, Busy, Done}); end
    compared++; if (PixAddr !== '0) begin mismatched++; $display("FAIL reset_pixaddr got %0d expected 0", PixAddr); end
    compared++; if (CdfAddr !== '0) begin mismatched++; $display("FAIL reset_cdfaddr got %0d expected 0", CdfAddr); end
    compared++; if (CdfMin !== '0) begin mismatched++; $display("FAIL reset_cdfmin got %0d expected 0", CdfMin); end
    compared++; if (ExprData !== '0) begin mismatched++; $display("FAIL reset_exprdata got %0d expected 0", ExprData); end
    #1 reset_n = 1'b1;
    Ready = 1'b1;
    $display("reset: released");
  endtask

  task automatic test_first_word();
    for (int i = 0; i < 256; i++) cdf_mem[i] = '0;
    cdf_mem[0] = 20'd5;
    for (int i = 0; i < 16; i++) pix_mem[i] = '0;
    run_frame(-1, 0, -1, -1, -1, to);
    compared++; if (to) begin mismatched++; $display("FAIL t1_timeout got timeout expected Done"); end
    compared++; if (cm_hist[2] !== 20'd0) begin mismatched++; $display("FAIL t1_cdfmin_c2 got %0d expected 0", cm_hist[2]); end
    compared++; if (cm_hist[3] !== 20'd5) begin mismatched++; $display("FAIL t1_cdfmin_c3 got %0d expected 5", cm_hist[3]); end
    compared++; if (scan_rd_cnt !== 2) begin mismatched++; $display("FAIL t1_scan_reads got %0d expected 2", scan_rd_cnt); end
    compared++; if (qget(pix_cyc, 0) !== 3) begin mismatched++; $display("FAIL t1_first_pixrd got %0d expected 3", qget(pix_cyc, 0)); end
    compared++; if (ex_cyc.size() !== 4) begin mismatched++; $display("FAIL t1_expr_count got %0d expected 4", ex_cyc.size()); end
    for (int i = 0; i < 4; i++) begin
      compared++; if (qget(ex_cyc, i) !== 5 + i) begin mismatched++; $display("FAIL t1_expr_cyc[%0d] got %0d expected %0d", i, qget(ex_cyc, i), 5 + i); end
      compared++; if (qget(ex_dat, i) !== 5) begin mismatched++; $display("FAIL t1_expr_dat[%0d] got %0d expected 5", i, qget(ex_dat, i)); end
    end
    compared++; if (done_cyc !== 9) begin mismatched++; $display("FAIL t1_done_cyc got %0d expected 9", done_cyc); end
    compared++; if (done_cnt !== 1) begin mismatched++; $display("FAIL t1_done_cnt got %0d expected 1", done_cnt); end
    compared++; if (busy_first !== 1) begin mismatched++; $display("FAIL t1_busy_first got %0d expected 1", busy_first); end
    compared++; if (busy_last !== 9) begin mismatched++; $display("FAIL t1_busy_last got %0d expected 9", busy_last); end
    compared++; if (busy_cnt !== 9) begin mismatched++; $display("FAIL t1_busy_cnt got %0d expected 9", busy_cnt); end
  endtask

  task automatic test_lookup();
    int exp_dat [4] = '{100, 345, 100, 0};
    load_cdf10();
    run_frame(-1, 0, -1, -1, -1, to);
    compared++; if (to) begin mismatched++; $display("FAIL t2_timeout got timeout expected Done"); end
    compared++; if (cm_hist[12] !== 20'd0) begin mismatched++; $display("FAIL t2_cdfmin_c12 got %0d expected 0", cm_hist[12]); end
    compared++; if (cm_hist[13] !== 20'd100) begin mismatched++; $display("FAIL t2_cdfmin_c13 got %0d expected 100", cm_hist[13]); end
    compared++; if (scan_max !== 11) begin mismatched++; $display("FAIL t2_scan_max got %0d expected 11", scan_max); end
    for (int i = 0; i < 4; i++) begin
      compared++; if (qget(pix_adr, i) !== i) begin mismatched++; $display("FAIL t2_pixaddr[%0d] got %0d expected %0d", i, qget(pix_adr, i), i); end
      compared++; if (qget(ex_dat, i) !== exp_dat[i]) begin mismatched++; $display("FAIL t2_expr_dat[%0d] got %0d expected %0d", i, qget(ex_dat, i), exp_dat[i]); end
    end
    compared++; if (qget(ex_cyc, 0) !== 15) begin mismatched++; $display("FAIL t2_first_expr got %0d expected 15", qget(ex_cyc, 0)); end
    compared++; if ((qget(ex_dat, 0) - 100) * 255 !== 0) begin mismatched++; $display("FAIL t2_dataout0 got %0d expected 0", (qget(ex_dat, 0) - 100) * 255); end
    compared++; if ((qget(ex_dat, 1) - 100) * 255 !== 62475) begin mismatched++; $display("FAIL t2_dataout1 got %0d expected 62475", (qget(ex_dat, 1) - 100) * 255); end
    compared++; if (done_cyc !== 19) begin mismatched++; $display("FAIL t2_done_cyc got %0d expected 19", done_cyc); end
  endtask

  task automatic test_all_zero();
    for (int i = 0; i < 256; i++) cdf_mem[i] = '0;
    pix_mem[0] = 8'd5; pix_mem[1] = 8'd6; pix_mem[2] = 8'd7; pix_mem[3] = 8'd8;
    run_frame(-1, 0, -1, -1, -1, to);
    compared++; if (to) begin mismatched++; $display("FAIL t3_timeout got timeout expected Done"); end
    compared++; if (qget(pix_cyc, 0) !== 258) begin mismatched++; $display("FAIL t3_run_start got %0d expected 258", qget(pix_cyc, 0)); end
    compared++; if (cm_hist[258] !== 20'd0) begin mismatched++; $display("FAIL t3_cdfmin got %0d expected 0", cm_hist[258]); end
    compared++; if (scan_rd_cnt !== 256) begin mismatched++; $display("FAIL t3_scan_reads got %0d expected 256", scan_rd_cnt); end
    compared++; if (scan_max !== 255) begin mismatched++; $display("FAIL t3_scan_max got %0d expected 255", scan_max); end
    compared++; if (ex_cyc.size() !== 4) begin mismatched++; $display("FAIL t3_expr_count got %0d expected 4", ex_cyc.size()); end
    compared++; if (qget(ex_cyc, 0) !== 260) begin mismatched++; $display("FAIL t3_first_expr got %0d expected 260", qget(ex_cyc, 0)); end
    compared++; if (done_cyc !== 264) begin mismatched++; $display("FAIL t3_done_cyc got %0d expected 264", done_cyc); end
    compared++; if (busy_last !== 264) begin mismatched++; $display("FAIL t3_busy_last got %0d expected 264", busy_last); end
  endtask

  task automatic test_ready_gap();
    int exp_pc [4] = '{3, 4, 8, 9};
    int exp_ec [4] = '{5, 6, 10, 11};
    for (int i = 0; i < 256; i++) cdf_mem[i] = (i <= 4) ? CDF_W'(5 + i) : '0;
    pix_mem[0] = 8'd1; pix_mem[1] = 8'd2; pix_mem[2] = 8'd3; pix_mem[3] = 8'd4;
    run_frame(5, 3, -1, -1, -1, to);
    compared++; if (to) begin mismatched++; $display("FAIL t4_timeout got timeout expected Done"); end
    compared++; if (pix_cyc.size() !== 4) begin mismatched++; $display("FAIL t4_pix_count got %0d expected 4", pix_cyc.size()); end
    compared++; if (ex_cyc.size() !== 4) begin mismatched++; $display("FAIL t4_expr_count got %0d expected 4", ex_cyc.size()); end
    for (int i = 0; i < 4; i++) begin
      compared++; if (qget(pix_cyc, i) !== exp_pc[i]) begin mismatched++; $display("FAIL t4_pix_cyc[%0d] got %0d expected %0d", i, qget(pix_cyc, i), exp_pc[i]); end
      compared++; if (qget(pix_adr, i) !== i) begin mismatched++; $display("FAIL t4_pixaddr[%0d] got %0d expected %0d", i, qget(pix_adr, i), i); end
      compared++; if (qget(ex_cyc, i) !== exp_ec[i]) begin mismatched++; $display("FAIL t4_expr_cyc[%0d] got %0d expected %0d", i, qget(ex_cyc, i), exp_ec[i]); end
      compared++; if (qget(ex_dat, i) !== 6 + i) begin mismatched++; $display("FAIL t4_expr_dat[%0d] got %0d expected %0d", i, qget(ex_dat, i), 6 + i); end
    end
    compared++; if (done_cyc !== 12) begin mismatched++; $display("FAIL t4_done_cyc got %0d expected 12", done_cyc); end
  endtask

  task automatic test_start_ignored();
    load_cdf10();
    run_frame(-1, 0, 5, 14, -1, to);
    compared++; if (to) begin mismatched++; $display("FAIL t5_timeout got timeout expected Done"); end
    compared++; if (scan_rd_cnt !== 12) begin mismatched++; $display("FAIL t5_scan_reads got %0d expected 12", scan_rd_cnt); end
    compared++; if (cm_hist[15] !== 20'd100) begin mismatched++; $display("FAIL t5_cdfmin_c15 got %0d expected 100", cm_hist[15]); end
    compared++; if (cm_hist[19] !== 20'd100) begin mismatched++; $display("FAIL t5_cdfmin_c19 got %0d expected 100", cm_hist[19]); end
    compared++; if (pix_cyc.size() !== 4) begin mismatched++; $display("FAIL t5_pix_count got %0d expected 4", pix_cyc.size()); end
    compared++; if (ex_cyc.size() !== 4) begin mismatched++; $display("FAIL t5_expr_count got %0d expected 4", ex_cyc.size()); end
    compared++; if (done_cyc !== 19) begin mismatched++; $display("FAIL t5_done_cyc got %0d expected 19", done_cyc); end
    compared++; if (done_cnt !== 1) begin mismatched++; $display("FAIL t5_done_cnt got %0d expected 1", done_cnt); end
  endtask

  task automatic test_abort();
    load_cdf10();
    run_frame(-1, 0, -1, -1, 15, to);
    compared++; if (qget(ex_cyc, 0) !== 15) begin mismatched++; $display("FAIL t6_pre_abort_expr got %0d expected 15", qget(ex_cyc, 0)); end
    compared++; if ({PixRd, CdfRd, ExprStart, Busy, Done} !== 5'b0) begin mismatched++; $display("FAIL t6_abort_strobes got %b expected 00000", {PixRd, CdfRd, ExprStart, Busy, Done}); end
    compared++; if (PixAddr !== '0) begin mismatched++; $display("FAIL t6_abort_pixaddr got %0d expected 0", PixAddr); end
    compared++; if (CdfAddr !== '0) begin mismatched++; $display("FAIL t6_abort_cdfaddr got %0d expected 0", CdfAddr); end
    compared++; if (CdfMin !== '0) begin mismatched++; $display("FAIL t6_abort_cdfmin got %0d expected 0", CdfMin); end
    compared++; if (ExprData !== '0) begin mismatched++; $display("FAIL t6_abort_exprdata got %0d expected 0", ExprData); end
    $display("abort: reset asserted mid-RUN");
    @(posedge clock); #3;
    reset_n = 1'b1;
    run_frame(-1, 0, -1, -1, -1, to);
    compared++; if (to) begin mismatched++; $display("FAIL t6_timeout got timeout expected Done"); end
    compared++; if (scan_first_cyc !== 1) begin mismatched++; $display("FAIL t6_scan_first_cyc got %0d expected 1", scan_first_cyc); end
    compared++; if (scan_first_adr !== 0) begin mismatched++; $display("FAIL t6_scan_first_adr got %0d expected 0", scan_first_adr); end
    compared++; if (qget(pix_adr, 0) !== 0) begin mismatched++; $display("FAIL t6_first_pixaddr got %0d expected 0", qget(pix_adr, 0)); end
    compared++; if (qget(ex_dat, 0) !== 100) begin mismatched++; $display("FAIL t6_first_expr_dat got %0d expected 100", qget(ex_dat, 0)); end
    compared++; if (done_cyc !== 19) begin mismatched++; $display("FAIL t6_done_cyc got %0d expected 19", done_cyc); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) pix_mem[i] = '0;
    for (int i = 0; i < 256; i++) cdf_mem[i] = '0;
    test_reset();
    test_first_word();
    test_lookup();
    test_all_zero();
    test_ready_gap();
    test_start_ignored();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
